muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit sitting between the register file read ports and the register file write port. It accepts two source operands (register file read data), a funct3 selector and a destination index. It computes the M-extension result over multiple cycles and issues a single-cycle write request (rd, data, write enable) toward the register file write port. The core stalls on `busy`.

---
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Core-side bundle for the multiply/divide unit.
// Handshake: the core raises start with funct3/rs1_data/rs2_data/rd_in
// valid; the unit samples them only while idle (busy = 0). Once accepted,
// busy stays high until the one-cycle done pulse, during which result,
// rd_out and reg_write are valid. start while busy is ignored.
interface muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        reg_write;
  logic [1:0]  state_dbg;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_in,
    input  busy, done, result, rd_out, reg_write, state_dbg
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_in,
    output busy, done, result, rd_out, reg_write, state_dbg
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Works on unsigned magnitudes for 32 iterations (shift-add multiply or
// restoring divide sharing one 64-bit working register) and applies the
// result sign when the final iteration is written into result.
module muldiv_unit (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        neg_q, neg_d;
  // m_q: multiplicand (multiply) or divisor (divide) magnitude
  logic [31:0] m_q, m_d;
  // p_q: {hi, lo}; multiply = {partial product, remaining multiplier},
  // divide = {partial remainder, dividend/quotient bits}
  logic [63:0] p_q, p_d;
  logic [31:0] result_q, result_d;

  // Operand decode at start time
  logic        a_signed, b_signed, sa, sb;
  logic [31:0] a_mag, b_mag;
  logic        neg_start;
  logic        div_zero, div_ovf, special;
  logic [31:0] special_res;

  // Iteration datapath
  logic [32:0] add_sum;
  logic [32:0] rem_shift, rem_diff;
  logic [63:0] step_p;
  logic [63:0] prod_signed;
  logic [31:0] quot_fix, rem_fix;
  logic [31:0] calc_res;

  // Signedness, magnitudes and special-case detection for the request
  always_comb begin
    // multiply: 000/001/010 have signed rs1, 000/001 signed rs2
    // divide: 100/110 are signed for both operands
    a_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    b_signed = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    sa       = a_signed & bus.rs1_data[31];
    sb       = b_signed & bus.rs2_data[31];
    a_mag    = sa ? (~bus.rs1_data + 32'd1) : bus.rs1_data;
    b_mag    = sb ? (~bus.rs2_data + 32'd1) : bus.rs2_data;
    // remainder takes the dividend's sign, everything else sign(A)^sign(B)
    neg_start = (bus.funct3[2] & bus.funct3[1]) ? sa : (sa ^ sb);
    div_zero  = bus.funct3[2] & (bus.rs2_data == 32'd0);
    div_ovf   = bus.funct3[2] & ~bus.funct3[0] &
                (bus.rs1_data == 32'h8000_0000) & (bus.rs2_data == 32'hFFFF_FFFF);
    special   = div_zero | div_ovf;
    special_res = 32'd0;
    if (div_zero) begin
      special_res = bus.funct3[1] ? bus.rs1_data : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      special_res = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One multiply or divide iteration plus final sign correction
  always_comb begin
    add_sum   = {1'b0, p_q[63:32]} + {1'b0, (p_q[0] ? m_q : 32'd0)};
    rem_shift = {p_q[63:32], p_q[31]};
    rem_diff  = rem_shift - {1'b0, m_q};
    if (!funct3_q[2]) begin
      step_p = {add_sum, p_q[31:1]};
    end else if (!rem_diff[32]) begin
      step_p = {rem_diff[31:0], p_q[30:0], 1'b1};
    end else begin
      step_p = {rem_shift[31:0], p_q[30:0], 1'b0};
    end
    prod_signed = neg_q ? (~step_p + 64'd1) : step_p;
    quot_fix    = neg_q ? (~step_p[31:0] + 32'd1) : step_p[31:0];
    rem_fix     = neg_q ? (~step_p[63:32] + 32'd1) : step_p[63:32];
    if (!funct3_q[2]) begin
      calc_res = (funct3_q[1:0] == 2'b00) ? prod_signed[31:0] : prod_signed[63:32];
    end else begin
      calc_res = funct3_q[1] ? rem_fix : quot_fix;
    end
  end

  // Next-state and datapath load control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    m_d      = m_q;
    p_d      = p_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          funct3_d = bus.funct3;
          rd_d     = bus.rd_in;
          neg_d    = neg_start;
          cnt_d    = 6'd0;
          m_d      = bus.funct3[2] ? b_mag : a_mag;
          p_d      = {32'd0, (bus.funct3[2] ? a_mag : b_mag)};
          if (special) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        p_d   = step_p;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          result_d = calc_res;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      funct3_q <= 3'd0;
      rd_q     <= 5'd0;
      neg_q    <= 1'b0;
      m_q      <= 32'd0;
      p_q      <= 64'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      m_q      <= m_d;
      p_q      <= p_d;
      result_q <= result_d;
    end
  end

  // Outputs decoded from state and latched fields
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    bus.reg_write = (state_q == DONE) && (rd_q != 5'd0);
    bus.result    = result_q;
    bus.rd_out    = rd_q;
    bus.state_dbg = state_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: each step issues one request and checks
// latency, busy coverage, result, rd_out, reg_write and the return to idle.
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at the next negedge and follow it to completion.
  // exp_lat counts falling edges after the accepting edge until done is seen.
  // inject_at >= 0 pulses a conflicting start at that point of the wait.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp,
                        input int exp_lat, input int inject_at);
    int   k;
    logic busy_ok;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.funct3   = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_in    = rd;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    bus.rd_in    = 5'($urandom_range(0, 31));
    k = 0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && k < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (k == inject_at) begin
        bus.start    = 1'b1;
        bus.funct3   = 3'b101;
        bus.rs1_data = 32'd50;
        bus.rs2_data = 32'd5;
        bus.rd_in    = 5'd9;
      end else begin
        bus.start    = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd1);
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_rd_out"}, {27'd0, bus.rd_out}, {27'd0, rd});
    check({tag, "_reg_write"}, {31'd0, bus.reg_write}, {31'd0, (rd != 5'd0)});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_result_held"}, bus.result, exp);
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.funct3   = 3'd0;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;
    bus.rd_in    = 5'd0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_reg_write", {31'd0, bus.reg_write}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rd_out", {27'd0, bus.rd_out}, 32'd0);
    check("rst_state", {30'd0, bus.state_dbg}, 32'd0);
    rst_n = 1'b1;

    // multiply
    run_op("mul_7_m3",      3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 32, -1);
    run_op("mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 32, -1);
    run_op("mulhu_max",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 32, -1);
    run_op("mulhsu_max",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 32, -1);

    // divide
    run_op("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 32, -1);
    run_op("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 32, -1);
    run_op("divu_100_7",    3'b101, 32'd100,       32'd7,         5'd12, 32'd14,        32, -1);
    run_op("remu_100_7",    3'b111, 32'd100,       32'd7,         5'd13, 32'd2,         32, -1);

    // special cases, back-to-back
    run_op("divu_by0",      3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 0,  -1);
    run_op("rem_by0",       3'b110, 32'd5,         32'd0,         5'd15, 32'd5,         0,  -1);
    run_op("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 0,  -1);
    run_op("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         0,  -1);

    // start while busy is ignored: 1000 / -10 = -100
    run_op("div_ignore",    3'b100, 32'd1000,      32'hFFFF_FFF6, 5'd18, 32'hFFFF_FF9C, 32, 9);

    // rd = 0: done pulses without a register write
    run_op("mul_rd0",       3'b000, 32'd6,         32'd7,         5'd0,  32'd42,        32, -1);

    // reset in the middle of a multiply
    @(negedge clk);
    bus.start    = 1'b1;
    bus.funct3   = 3'b000;
    bus.rs1_data = 32'd123;
    bus.rs2_data = 32'd456;
    bus.rd_in    = 5'd7;
    @(negedge clk);
    bus.start    = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_reg_write", {31'd0, bus.reg_write}, 32'd0);
    check("midrst_result", bus.result, 32'd0);
    check("midrst_rd_out", {27'd0, bus.rd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_idle", {31'd0, bus.busy}, 32'd0);

    run_op("mul_after_rst", 3'b000, 32'h0001_2345, 32'h0000_0100, 5'd3, 32'h0123_4500, 32, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
